// File: rtl/mem_ctrl_banked_if.sv
// Host request/response bundle for mem_ctrl_banked.
// The host drives requests (master); the controller accepts them and returns read data (slave).
interface mem_ctrl_banked_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_ctrl_banked.sv
// Multi-bank DRAM-style command controller.
// Uses an open-row policy per bank and inserts periodic refresh between requests.
module mem_ctrl_banked #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ROW_W  = 4,
  parameter int unsigned COL_W  = 12,
  parameter int unsigned T_RCD  = 4,
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_CAS  = 2,
  parameter int unsigned T_WR   = 3,
  parameter int unsigned T_REFI = 320,
  parameter int unsigned T_RFC  = 6
) (
  input  logic                clk,
  input  logic                rst,
  mem_ctrl_banked_if.slave    host,
  output logic                cs_n,
  output logic [2:0]          command,
  output logic [BANK_W-1:0]   ba,
  output logic [ROW_W-1:0]    RA,
  output logic [COL_W-1:0]    CA,
  output logic [DATA_W-1:0]   dq_out,
  output logic                dq_oe,
  input  logic [DATA_W-1:0]   dq_in
);
  localparam int unsigned BANKS  = 2**BANK_W;
  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int unsigned REF_W  = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam int unsigned CNT_W  = $clog2(T_RCD + T_RP + T_CAS + T_WR + T_RFC + 1);

  typedef enum logic [2:0] {
    CMD_NOP     = 3'b000,
    CMD_ACT     = 3'b001,
    CMD_READ    = 3'b010,
    CMD_WRITE   = 3'b011,
    CMD_PRE     = 3'b100,
    CMD_REFRESH = 3'b101,
    CMD_PREA    = 3'b110
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, ACT_WAIT, PRE_WAIT, RW, READ_WAIT, WR_REC, REF_PREA_WAIT, REF_WAIT
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  cmd_t               cmd_q, cmd_d;
  logic [BANK_W-1:0]  ba_d;
  logic [ROW_W-1:0]   ra_d;
  logic [COL_W-1:0]   ca_d;
  logic [DATA_W-1:0]  dq_out_d;
  logic               dq_oe_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic               lat_we;
  logic [BANK_W-1:0]  lat_bank;
  logic [ROW_W-1:0]   lat_row;
  logic [COL_W-1:0]   lat_col;
  logic [DATA_W-1:0]  lat_wdata;

  logic [BANKS-1:0]   row_open;
  logic [ROW_W-1:0]   open_row [BANKS];

  logic [REF_W-1:0]   ref_cnt;
  logic               ref_pending;
  logic               ref_expire;
  logic               ref_clear;

  logic               accept;
  logic               issue_rw;
  logic [BANK_W-1:0]  req_bank;
  logic [ROW_W-1:0]   req_row;
  logic [COL_W-1:0]   req_col;
  logic               rw_we;
  logic [BANK_W-1:0]  rw_bank;
  logic [COL_W-1:0]   rw_col;
  logic [DATA_W-1:0]  rw_wdata;

  assign req_bank = host.req_addr[ADDR_W-1 -: BANK_W];
  assign req_row  = host.req_addr[COL_W +: ROW_W];
  assign req_col  = host.req_addr[COL_W-1:0];

  assign host.req_ready = (state == IDLE) && !ref_pending;
  assign accept         = host.req_valid && host.req_ready;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;
  assign command        = cmd_q;
  assign ref_expire     = (ref_cnt == REF_W'(T_REFI - 1));

  // A row hit issues READ/WRITE straight from IDLE, before the request is latched.
  assign rw_we    = (state == IDLE) ? host.req_we    : lat_we;
  assign rw_bank  = (state == IDLE) ? req_bank       : lat_bank;
  assign rw_col   = (state == IDLE) ? req_col        : lat_col;
  assign rw_wdata = (state == IDLE) ? host.req_wdata : lat_wdata;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cmd_d       = CMD_NOP;
    ba_d        = ba;
    ra_d        = RA;
    ca_d        = CA;
    dq_out_d    = '0;
    dq_oe_d     = 1'b0;
    rsp_valid_d = 1'b0;
    issue_rw    = 1'b0;
    ref_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (ref_pending) begin
          if (|row_open) begin
            cmd_d   = CMD_PREA;
            state_d = REF_PREA_WAIT;
            cnt_d   = CNT_W'(T_RP - 1);
          end else begin
            cmd_d     = CMD_REFRESH;
            ref_clear = 1'b1;
            state_d   = REF_WAIT;
            cnt_d     = CNT_W'(T_RFC);
          end
        end else if (host.req_valid) begin
          if (row_open[req_bank] && (open_row[req_bank] == req_row)) begin
            issue_rw = 1'b1;
          end else if (row_open[req_bank]) begin
            cmd_d   = CMD_PRE;
            ba_d    = req_bank;
            state_d = PRE_WAIT;
            cnt_d   = CNT_W'(T_RP - 1);
          end else begin
            cmd_d   = CMD_ACT;
            ba_d    = req_bank;
            ra_d    = req_row;
            state_d = ACT_WAIT;
            cnt_d   = CNT_W'(T_RCD - 1);
          end
        end
      end
      PRE_WAIT: begin
        if (cnt == '0) begin
          cmd_d   = CMD_ACT;
          ba_d    = lat_bank;
          ra_d    = lat_row;
          state_d = ACT_WAIT;
          cnt_d   = CNT_W'(T_RCD - 1);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      ACT_WAIT: begin
        if (cnt == '0) issue_rw = 1'b1;
        else           cnt_d    = cnt - CNT_W'(1);
      end
      RW: begin
        if (lat_we) begin
          state_d = WR_REC;
          cnt_d   = CNT_W'(T_WR - 1);
        end else begin
          state_d = READ_WAIT;
          cnt_d   = CNT_W'(T_CAS - 1);
        end
      end
      READ_WAIT: begin
        if (cnt == '0) begin
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      WR_REC, REF_WAIT: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      REF_PREA_WAIT: begin
        if (cnt == '0) begin
          cmd_d     = CMD_REFRESH;
          ref_clear = 1'b1;
          state_d   = REF_WAIT;
          cnt_d     = CNT_W'(T_RFC);
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue_rw) begin
      cmd_d    = rw_we ? CMD_WRITE : CMD_READ;
      ba_d     = rw_bank;
      ca_d     = rw_col;
      dq_oe_d  = rw_we;
      dq_out_d = rw_we ? rw_wdata : '0;
      state_d  = RW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_q       <= CMD_NOP;
      cs_n        <= 1'b1;
      ba          <= '0;
      RA          <= '0;
      CA          <= '0;
      dq_out      <= '0;
      dq_oe       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      lat_we      <= 1'b0;
      lat_bank    <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      lat_wdata   <= '0;
      row_open    <= '0;
      for (int unsigned b = 0; b < BANKS; b++) open_row[b] <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      cmd_q       <= cmd_d;
      cs_n        <= (cmd_d == CMD_NOP);
      ba          <= ba_d;
      RA          <= ra_d;
      CA          <= ca_d;
      dq_out      <= dq_out_d;
      dq_oe       <= dq_oe_d;
      rsp_valid_q <= rsp_valid_d;
      if (rsp_valid_d) rsp_rdata_q <= dq_in;
      if (accept) begin
        lat_we    <= host.req_we;
        lat_bank  <= req_bank;
        lat_row   <= req_row;
        lat_col   <= req_col;
        lat_wdata <= host.req_wdata;
      end
      // Row bookkeeping follows the command being issued this edge.
      case (cmd_d)
        CMD_ACT: begin
          row_open[ba_d] <= 1'b1;
          open_row[ba_d] <= ra_d;
        end
        CMD_PRE:  row_open[ba_d] <= 1'b0;
        CMD_PREA: row_open       <= '0;
        default: ;
      endcase
      ref_cnt     <= ref_expire ? '0 : ref_cnt + REF_W'(1);
      ref_pending <= ref_clear ? 1'b0 : (ref_expire ? 1'b1 : ref_pending);
    end
  end
endmodule

// File: doc/mem_ctrl_banked.md
Name: mem_ctrl_banked

Overview:
Parametrised, multi-bank successor to the single-bank memory controller. It accepts host read/write requests through a valid/ready handshake and translates each into a timed command stream (ACT/READ/WRITE/PRE/PREA/REFRESH) for an external DRAM-style array. It keeps an open-row policy per bank and schedules periodic refresh. It sits between the host request fabric and the memory device pins.

Parameters:
DATA_W, 32, data bus width
BANK_W, 2, bank address bits (BANKS = 2**BANK_W)
ROW_W, 4, row address bits
COL_W, 12, column address bits
T_RCD, 4, ACT to READ/WRITE cycles (>=1)
T_RP, 3, PRE/PREA to next command cycles (>=1)
T_CAS, 2, READ command to dq_in sample cycles (>=1)
T_WR, 3, WRITE to next command cycles (>=1)
T_REFI, 320, refresh interval cycles
T_RFC, 6, REFRESH to next command cycles (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  BANK_W+ROW_W+COL_W  {bank,row,col}
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid, 1-cycle pulse
rsp_rdata  out  DATA_W  read data
cs_n  out  1  chip select, low whenever command!=NOP
command  out  3  NOP=000 ACT=001 READ=010 WRITE=011 PRE=100 REFRESH=101 PREA=110 (111 unused)
ba  out  BANK_W  bank address
RA  out  ROW_W  row address (ACT)
CA  out  COL_W  column address (READ/WRITE)
dq_out  out  DATA_W  write data to device
dq_oe  out  1  dq_out drive enable
dq_in  in  DATA_W  read data from device

Behaviour:
- Reset values: command=NOP, cs_n=1, ba/RA/CA=0, dq_out=0, dq_oe=0, rsp_valid=0, rsp_rdata=0. All row_open bits=0, refresh counter=0, ref_pending=0, state=IDLE.
- Reset asserted mid-operation aborts the operation immediately. No response is produced for the aborted request.
- All pin outputs are registered. req_ready = (state==IDLE) && !ref_pending. It is combinational.
- Accept when req_valid && req_ready at edge N. Latch we/addr/wdata.
- Per-bank state is row_open[b] and open_row[b]. Rows stay open after access; there is no auto-precharge.
- Decode at accept, with the first command driven in cycle N+1:
  - Hit (row_open && open_row==row): READ/WRITE in N+1.
  - Closed: ACT in N+1, NOP for T_RCD-1 cycles, then READ/WRITE.
  - Conflict (open, different row): PRE(ba) in N+1, then ACT at N+1+T_RP, then READ/WRITE T_RCD after the ACT.
- WRITE cycle: dq_oe=1 and dq_out=wdata for that cycle only. Then T_WR NOP cycles. Then IDLE.
- READ cycle: sample dq_in at the end of cycle READ+T_CAS. rsp_valid=1 and rsp_rdata=sample in the following cycle. The state is IDLE in that same cycle. Hit read latency, accept edge to rsp_valid, is T_CAS+2 cycles.
- ACT updates open_row[b]=row and row_open[b]=1. PRE clears row_open[b]. PREA clears all row_open bits.
- State machine: IDLE, ACT_WAIT, PRE_WAIT, RW, READ_WAIT, WR_REC, REF_PREA_WAIT, REF_WAIT.
- Refresh counter increments every cycle. At T_REFI-1 it wraps to 0 and sets ref_pending. An expiry while ref_pending is already set is ignored; only one refresh is ever pending.
- An in-flight request completes before refresh begins.
- In IDLE with ref_pending (takes priority over a simultaneous req_valid):
  - If any row is open: PREA, wait T_RP, then REFRESH.
  - Otherwise: REFRESH directly.
  - ref_pending clears in the REFRESH cycle. After REFRESH, T_RFC NOP cycles, then IDLE.
- Commands are issued at most one per cycle. cs_n = (command==NOP).

Test Plan:
- Reset, then write 0xDEADBEEF to bank1 row3 col0x010 (closed bank) -> ACT(ba=1,RA=3) in N+1; WRITE(CA=0x010, dq_oe=1, dq_out=0xDEADBEEF) in N+5; req_ready low until N+9.
- Read same address again (row hit), device returns 0xDEADBEEF on dq_in -> READ in N+1; rsp_valid with 0xDEADBEEF at N+4; no ACT issued.
- Read bank1 row7 (conflict) -> PRE(ba=1) in N+1, ACT(RA=7) in N+4, READ in N+8; open_row[1]=7 afterwards.
- Open rows in banks 0 and 2, then run to T_REFI expiry -> PREA, REFRESH 3 cycles later, 6 NOPs; req_ready=0 throughout; next access to bank0 issues ACT (row closed).
- req_valid held high on the same cycle refresh expires in IDLE -> request not accepted; refresh sequence runs first; request accepted afterwards.
- Assert rst during ACT_WAIT -> command=NOP, cs_n=1, rsp_valid never pulses; req_ready=1 one cycle after rst deasserts.
